// File: rtl/crossing_sequencer.sv
// Pelican crossing controller: sequences car and pedestrian lamps through a safe
// phase order, latches pedestrian requests, enforces minimum car-green and all-red
// clearance, and provides a flashing night mode. All timing is counted in ticks.
module crossing_sequencer #(
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned T_MIN_GREEN = 20,
   parameter int unsigned T_YELLOW    = 4,
   parameter int unsigned T_ALL_RED   = 2,
   parameter int unsigned T_WALK      = 10,
   parameter int unsigned T_CLEAR     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       button,
   input  logic       night,
   output logic       green_c,
   output logic       yellow_c,
   output logic       red_c,
   output logic       green_p,
   output logic       yellow_p,
   output logic       red_p,
   output logic       wait_lamp,
   output logic [2:0] phase
);

   localparam logic [2:0] CAR_GO   = 3'd0;
   localparam logic [2:0] CAR_YEL  = 3'd1;
   localparam logic [2:0] ALL_RED1 = 3'd2;
   localparam logic [2:0] PED_WALK = 3'd3;
   localparam logic [2:0] PED_CLR  = 3'd4;
   localparam logic [2:0] ALL_RED2 = 3'd5;
   localparam logic [2:0] NIGHT    = 3'd6;

   // Timer value on the last tick of each phase (a phase of T ticks ends at T-1).
   localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(T_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(T_YELLOW - 1);
   localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(T_ALL_RED - 1);
   localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(T_WALK - 1);
   localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(T_CLEAR - 1);
   localparam logic [CNT_W-1:0] TIMER_MAX  = '1;
   localparam logic [CNT_W-1:0] TIMER_ONE  = CNT_W'(1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             req_q, req_d;
   logic             flash_q, flash_d;

   // Phase sequencing; only a tick can move the crossing, except the unused encoding.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         CAR_GO: begin
            if (tick) begin
               if (night) begin
                  state_d = NIGHT;
               end else if (req_q && (timer_q >= GREEN_LAST)) begin
                  state_d = CAR_YEL;
               end
            end
         end
         CAR_YEL:  if (tick && (timer_q == YEL_LAST))  state_d = ALL_RED1;
         ALL_RED1: if (tick && (timer_q == RED_LAST))  state_d = PED_WALK;
         PED_WALK: if (tick && (timer_q == WALK_LAST)) state_d = PED_CLR;
         PED_CLR:  if (tick && (timer_q == CLR_LAST))  state_d = ALL_RED2;
         ALL_RED2: if (tick && (timer_q == RED_LAST))  state_d = CAR_GO;
         // Leaving night always passes through all-red before cars get green.
         NIGHT:    if (tick && !night)                 state_d = ALL_RED2;
         default:  state_d = CAR_GO;
      endcase
   end

   // Phase timer: restarts on any phase change, counts ticks, saturates.
   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q) begin
         timer_d = '0;
      end else if (tick && (timer_q != TIMER_MAX)) begin
         timer_d = timer_q + TIMER_ONE;
      end
   end

   // Request latch: cleared in night, reloaded from the button on walk entry.
   always_comb begin
      req_d = req_q | button;
      if ((state_q == NIGHT) || (state_d == NIGHT)) begin
         req_d = 1'b0;
      end else if ((state_d == PED_WALK) && (state_q != PED_WALK)) begin
         req_d = button;
      end
   end

   // Night flash: starts dark on entry, toggles each tick while in night.
   always_comb begin
      flash_d = flash_q;
      if ((state_d == NIGHT) && (state_q != NIGHT)) begin
         flash_d = 1'b0;
      end else if ((state_q == NIGHT) && tick) begin
         flash_d = ~flash_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CAR_GO;
         timer_q <= '0;
         req_q   <= 1'b0;
         flash_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         req_q   <= req_d;
         flash_q <= flash_d;
      end
   end

   // Lamp decode straight from the state register; unused encoding shows all red.
   always_comb begin
      green_c  = 1'b0;
      yellow_c = 1'b0;
      red_c    = 1'b0;
      green_p  = 1'b0;
      yellow_p = 1'b0;
      red_p    = 1'b0;
      unique case (state_q)
         CAR_GO: begin
            green_c = 1'b1;
            red_p   = 1'b1;
         end
         CAR_YEL: begin
            yellow_c = 1'b1;
            red_p    = 1'b1;
         end
         PED_WALK: begin
            red_c   = 1'b1;
            green_p = 1'b1;
         end
         PED_CLR: begin
            red_c    = 1'b1;
            yellow_p = 1'b1;
         end
         NIGHT: begin
            yellow_c = flash_q;
            yellow_p = flash_q;
         end
         default: begin
            red_c = 1'b1;
            red_p = 1'b1;
         end
      endcase
   end

   assign wait_lamp = req_q;
   assign phase     = state_q;

endmodule

// File: tb/tb_crossing_sequencer.sv
// Scoreboard bench for crossing_sequencer: a phase/tick-count reference model pushes
// expected outputs per clock; a monitor pops and compares on the falling edge.
module tb_crossing_sequencer;

   localparam int unsigned CNT_W       = 8;
   localparam int unsigned T_MIN_GREEN = 20;
   localparam int unsigned T_YELLOW    = 4;
   localparam int unsigned T_ALL_RED   = 2;
   localparam int unsigned T_WALK      = 10;
   localparam int unsigned T_CLEAR     = 4;

   logic       clk = 1'b0;
   logic       rst, tick, button, night;
   logic       green_c, yellow_c, red_c, green_p, yellow_p, red_p, wait_lamp;
   logic [2:0] phase;

   always #5 clk = ~clk;

   crossing_sequencer #(
      .CNT_W      (CNT_W),
      .T_MIN_GREEN(T_MIN_GREEN),
      .T_YELLOW   (T_YELLOW),
      .T_ALL_RED  (T_ALL_RED),
      .T_WALK     (T_WALK),
      .T_CLEAR    (T_CLEAR)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .button   (button),
      .night    (night),
      .green_c  (green_c),
      .yellow_c (yellow_c),
      .red_c    (red_c),
      .green_p  (green_p),
      .yellow_p (yellow_p),
      .red_p    (red_p),
      .wait_lamp(wait_lamp),
      .phase    (phase)
   );

   logic [9:0] exp_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;

   // Reference model: phase number, ticks completed in phase, request, flash.
   int m_ph    = 0;
   int m_ticks = 0;
   bit m_req   = 1'b0;
   bit m_flash = 1'b0;
   bit cur_night = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int dur(input int ph);
      case (ph)
         1:       return T_YELLOW;
         2, 5:    return T_ALL_RED;
         3:       return T_WALK;
         4:       return T_CLEAR;
         default: return 0;
      endcase
   endfunction

   // {green_c, yellow_c, red_c, green_p, yellow_p, red_p}
   function automatic logic [5:0] exp_lamps(input int ph, input bit f);
      case (ph)
         0:       return 6'b100_001;
         1:       return 6'b010_001;
         3:       return 6'b001_100;
         4:       return 6'b001_010;
         6:       return {1'b0, f, 1'b0, 1'b0, f, 1'b0};
         default: return 6'b001_001;
      endcase
   endfunction

   function void model_step(input bit r, input bit t, input bit b, input bit n);
      int nxt;
      if (r) begin
         m_ph = 0; m_ticks = 0; m_req = 1'b0; m_flash = 1'b0;
         return;
      end
      nxt = m_ph;
      if (t) begin
         if (m_ph == 0) begin
            if (n) nxt = 6;
            else if (m_req && (m_ticks + 1 >= int'(T_MIN_GREEN))) nxt = 1;
         end else if (m_ph == 6) begin
            if (!n) nxt = 5;
         end else if (m_ticks + 1 == dur(m_ph)) begin
            nxt = (m_ph == 5) ? 0 : m_ph + 1;
         end
      end
      if (m_ph == 6 || nxt == 6) m_req = 1'b0;
      else if (nxt == 3 && m_ph != 3) m_req = b;
      else m_req = m_req | b;
      if (nxt == 6 && m_ph != 6) m_flash = 1'b0;
      else if (m_ph == 6 && t) m_flash = ~m_flash;
      if (nxt != m_ph) m_ticks = 0;
      else if (t) m_ticks++;
      m_ph = nxt;
   endfunction

   // One clock: drive inputs, advance model, queue expectation for after the edge.
   task automatic step(input bit r, input bit t, input bit b, input bit n);
      rst = r; tick = t; button = b; night = n;
      model_step(r, t, b, n);
      @(posedge clk);
      exp_q.push_back({exp_lamps(m_ph, m_flash), m_req, 3'(m_ph)});
      #1;
   endtask

   task automatic run_ticks(input int k);
      repeat (k) begin
         repeat (3) step(1'b0, 1'b0, 1'b0, cur_night);
         step(1'b0, 1'b1, 1'b0, cur_night);
      end
   endtask

   task automatic press();
      step(1'b0, 1'b0, 1'b1, cur_night);
   endtask

   task automatic do_reset();
      cur_night = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic wait_phase(input logic [2:0] p, input int limit);
      int n = 0;
      while (phase !== p && n < limit) begin
         run_ticks(1);
         n++;
      end
      if (phase !== p) chk("wait_phase_timeout", 32'(phase), 32'(p));
   endtask

   // Count ticks until the DUT reaches phase p (bounded).
   task automatic ticks_to(input logic [2:0] p, output int n);
      n = 0;
      do begin
         run_ticks(1);
         n++;
      end while (phase !== p && n < 200);
   endtask

   // Monitor: every clock presents a full lamp/phase word to compare.
   initial begin
      logic [9:0] e, act;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            act = {green_c, yellow_c, red_c, green_p, yellow_p, red_p, wait_lamp, phase};
            chk("outputs", 32'(act), 32'(e));
            chk("green_overlap", 32'(green_c & green_p), 32'd0);
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1; tick = 1'b0; button = 1'b0; night = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset and idle
      do_reset();
      run_ticks(200);
      chk("idle_phase", 32'(phase), 32'd0);

      // Early press at tick 3: yellow on tick 20, 22-tick pedestrian cycle
      do_reset();
      run_ticks(3);
      press();
      chk("wait_rise", 32'(wait_lamp), 32'd1);
      ticks_to(3'd1, n);
      chk("yel_entry_tick", 32'(n + 3), 32'd20);
      ticks_to(3'd0, n);
      chk("ped_cycle_ticks", 32'(n), 32'd22);

      // Late press: yellow on next tick; re-request gives 20 ticks of green
      do_reset();
      run_ticks(50);
      press();
      run_ticks(1);
      chk("late_yel", 32'(phase), 32'd1);
      wait_phase(3'd3, 50);
      press();
      chk("rerequest", 32'(wait_lamp), 32'd1);
      wait_phase(3'd0, 50);
      ticks_to(3'd1, n);
      chk("regreen_ticks", 32'(n), 32'd20);

      // Night raised during pedestrian clearance
      wait_phase(3'd4, 50);
      cur_night = 1'b1;
      wait_phase(3'd0, 50);
      run_ticks(1);
      chk("night_entry", 32'(phase), 32'd6);
      chk("flash_start", 32'(yellow_c), 32'd0);
      run_ticks(1);
      chk("flash_toggle", 32'(yellow_p), 32'd1);
      press();
      chk("night_wait", 32'(wait_lamp), 32'd0);
      run_ticks(5);
      cur_night = 1'b0;
      run_ticks(1);
      chk("night_exit_1", 32'(phase), 32'd5);
      run_ticks(1);
      chk("night_exit_2", 32'(phase), 32'd5);
      run_ticks(1);
      chk("night_exit_go", 32'(phase), 32'd0);

      // Reset mid-walk with a request pending
      press();
      wait_phase(3'd3, 100);
      press();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst_phase", 32'(phase), 32'd0);
      chk("rst_wait", 32'(wait_lamp), 32'd0);
      press();
      ticks_to(3'd1, n);
      chk("rst_regreen", 32'(n), 32'd20);

      // Randomized traffic
      repeat (3000) begin
         if ($urandom_range(0, 149) == 0) cur_night = ~cur_night;
         step(($urandom_range(0, 399) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 7) == 0), cur_night);
      end

      @(negedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/crossing_sequencer.md
# crossing_sequencer

Timed controller for the pelican crossing: sequences the car and pedestrian lamp sets through a safe phase order. It latches pedestrian requests and enforces a minimum car-green time plus all-red clearance intervals. A night flashing mode is also provided. It sits between the push-button/tick sources and the lamp drivers, and is the single owner of the crossing's lamp state.

## Interface
- `CNT_W`, 8: width of the phase timer (ticks).
- `T_MIN_GREEN`, 20: minimum ticks in CAR_GO before a request is served.
- `T_YELLOW`, 4: ticks in CAR_YEL.
- `T_ALL_RED`, 2: ticks in each all-red state.
- `T_WALK`, 10: ticks in PED_WALK.
- `T_CLEAR`, 4: ticks in PED_CLR.
- Constraint: every `T_*` is in 1..2^CNT_W−1.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: one-cycle timebase strobe; all timing counts in ticks.
- `button` in 1: pedestrian push-button, level-sampled every cycle.
- `night` in 1: request flashing night mode.
- `green_c`, `yellow_c`, `red_c` out 1 each: car lamps.
- `green_p`, `yellow_p`, `red_p` out 1 each: pedestrian lamps.
- `wait_lamp` out 1: request pending indicator (equals request latch).
- `phase` out 3: current state encoding, for debug.

## Operation
- States and encodings, with lamps lit:
  - CAR_GO=0: green_c, red_p.
  - CAR_YEL=1: yellow_c, red_p.
  - ALL_RED1=2: red_c, red_p.
  - PED_WALK=3: red_c, green_p.
  - PED_CLR=4: red_c, yellow_p.
  - ALL_RED2=5: red_c, red_p.
  - NIGHT=6: yellow_c and yellow_p both driven by the flash bit; all other lamps off.
- Lamps are a pure decode of the state register (plus the flash bit in NIGHT). Encodings 7 go to CAR_GO on the next clock.
- Timer: reset to 0 on every state change. It increments on each tick cycle and saturates at 2^CNT_W−1.
- Transitions are evaluated only on cycles with `tick`=1:
  - Timed states (CAR_YEL, ALL_RED1, PED_WALK, PED_CLR, ALL_RED2): advance in order when timer == T_x−1, so each lasts exactly T_x ticks. ALL_RED2 advances to CAR_GO.
  - CAR_GO with `night`=1: go to NIGHT. This has priority over a request and ignores the minimum green.
  - CAR_GO with request latched and timer ≥ T_MIN_GREEN−1: go to CAR_YEL.
  - NIGHT with `night`=0: go to ALL_RED2, never directly to CAR_GO.
- `night` is ignored in every state other than CAR_GO and NIGHT; the running sequence always completes first.
- Request latch:
  - Set on any cycle with `button`=1, outside NIGHT.
  - On the clock that enters PED_WALK, it loads `button`: a press in that same cycle survives, otherwise it clears.
  - Presses during PED_WALK, PED_CLR and ALL_RED2 set it again for the next cycle of the sequence.
  - In NIGHT it is held at 0.
- Flash bit: cleared on NIGHT entry, toggles on every tick while in NIGHT.
- Safety invariants: green_c and green_p are never both 1. Outside NIGHT, exactly one car lamp and exactly one pedestrian lamp are lit.

## Timing
- Reset values: state CAR_GO, timer 0, request 0, flash 0. Hence green_c=1, red_p=1, all other lamps 0, wait_lamp=0, phase=0.
- `rst` mid-sequence, from any state, returns to CAR_GO on the next edge, with the request dropped and the timer at 0.
- Lamp latency: outputs change on the clock edge that samples the deciding `tick`, so they are visible the cycle after the tick.
- `wait_lamp` rises on the edge after the first `button`=1 cycle.
- Minimum request-to-walk time, counted from a tick taken in CAR_GO with timer ≥ T_MIN_GREEN−1: T_YELLOW + T_ALL_RED ticks.
- A full pedestrian cycle lasts T_YELLOW + 2·T_ALL_RED + T_WALK + T_CLEAR ticks; with defaults this is 22 ticks from leaving CAR_GO to re-entering it.
- A button held continuously produces back-to-back sequences, each separated by exactly T_MIN_GREEN ticks of CAR_GO.

## Test plan
- Reset and idle: assert rst, tick every 4 cycles, button=0 for 200 ticks. Required: phase stays 0, green_c=1, red_p=1, wait_lamp=0 throughout.
- Early press: pulse button one cycle at tick 3 after reset. Required: wait_lamp=1 from the next cycle; CAR_YEL is entered on the tick-20 edge.
  - Then, with defaults: ALL_RED1 at +4 ticks, PED_WALK at +6, PED_CLR at +16, ALL_RED2 at +20, CAR_GO at +22.
  - wait_lamp=0 from PED_WALK entry; green_c and green_p never overlap.
- Late press and re-request: press at tick 50 after reset. Required: CAR_YEL on the next tick. A second press during PED_WALK re-asserts wait_lamp, and CAR_YEL follows exactly 20 ticks after CAR_GO re-entry.
- Night mode: raise night during PED_CLR. Required: the sequence finishes, CAR_GO is entered, and NIGHT follows on the next tick.
  - In NIGHT, yellow_c/yellow_p toggle every tick starting off, and button presses leave wait_lamp=0.
  - Dropping night gives ALL_RED2 for 2 ticks, then CAR_GO.
- Reset mid-walk: assert rst for one cycle in PED_WALK with a request pending. Required: the next cycle shows phase=0, green_c=1, red_p=1, wait_lamp=0, and the min-green count restarts from 0.
